// File: rtl/tnn_vote_accumulator.sv
// tnn_vote_accumulator
// Collects tagged neuron fire bits into one saturating vote counter per class.
// At frame end it runs a one-class-per-cycle argmax and offers the winner downstream.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                beat handshake (in_ready registered)
//   in_vote, in_class, in_last       fire bit, class tag, end-of-frame marker
//   out_valid/out_ready              result handshake (out_valid registered)
//   out_class, out_score             winning class and its vote count (registered)
module tnn_vote_accumulator #(
    parameter int unsigned NUM_CLASSES = 7,
    parameter int unsigned CLS_W       = 3,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_vote,
    input  logic [CLS_W-1:0] in_class,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] out_class,
    output logic [CNT_W-1:0] out_score
);

    // Scan index must reach NUM_CLASSES itself (the result-commit step).
    localparam int unsigned IDX_W = CLS_W + 1;
    localparam logic [IDX_W-1:0] NUM_CLS_L = IDX_W'(NUM_CLASSES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CLS_W-1:0] best_cls_q, best_cls_d;
    logic [CNT_W-1:0] best_score_q, best_score_d;
    logic [CLS_W-1:0] out_class_q, out_class_d;
    logic [CNT_W-1:0] out_score_q, out_score_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] scan_cnt;

    // Next-state, counter update and argmax datapath
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        best_cls_d   = best_cls_q;
        best_score_d = best_score_q;
        out_class_d  = out_class_q;
        out_score_d  = out_score_q;
        out_valid_d  = out_valid_q;
        in_ready_d   = in_ready_q;
        scan_cnt     = '0;

        case (state_q)
            ST_ACCUM: begin
                if (in_valid && in_ready_q) begin
                    // Out-of-range class tags are consumed without touching any counter.
                    if (in_vote && ({1'b0, in_class} < NUM_CLS_L)) begin
                        if (cnt_q[in_class] != CNT_MAX) begin
                            cnt_d[in_class] = cnt_q[in_class] + CNT_W'(1);
                        end
                    end
                    if (in_last) begin
                        state_d    = ST_SCAN;
                        idx_d      = '0;
                        in_ready_d = 1'b0;
                    end
                end
            end

            ST_SCAN: begin
                if (idx_q < NUM_CLS_L) begin
                    scan_cnt = cnt_q[idx_q[CLS_W-1:0]];
                    // Index 0 seeds the best; strict compare keeps the lowest index on ties.
                    if ((idx_q == '0) || (scan_cnt > best_score_q)) begin
                        best_cls_d   = idx_q[CLS_W-1:0];
                        best_score_d = scan_cnt;
                    end
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    // Extra step registers the final best into the output holding regs.
                    out_class_d = best_cls_q;
                    out_score_d = best_score_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end

            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                        cnt_d[i] = '0;
                    end
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_ACCUM;
                end
            end

            default: begin
                for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                    cnt_d[i] = '0;
                end
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACCUM;
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                cnt_q[i] <= '0;
            end
            idx_q        <= '0;
            best_cls_q   <= '0;
            best_score_q <= '0;
            out_class_q  <= '0;
            out_score_q  <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            best_cls_q   <= best_cls_d;
            best_score_q <= best_score_d;
            out_class_q  <= out_class_d;
            out_score_q  <= out_score_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_score = out_score_q;

endmodule
